// File: rtl/hpdcache_pkg.sv
// Shared write-channel payload types for the HPDcache memory-side responder.
package hpdcache_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned BE_W   = DATA_W / 8;

  typedef logic [ID_W-1:0] hpdcache_mem_id_t;

  typedef struct packed {
    logic [ADDR_W-1:0] mem_req_addr;
    hpdcache_mem_id_t  mem_req_id;
  } hpdcache_mem_req_t;

  typedef struct packed {
    logic [DATA_W-1:0] mem_req_w_data;
    logic [BE_W-1:0]   mem_req_w_be;
  } hpdcache_mem_req_w_t;

  typedef struct packed {
    hpdcache_mem_id_t mem_resp_w_id;
  } hpdcache_mem_resp_w_t;

endpackage

// File: rtl/hpdcache_fifo_reg.sv
// Registered FIFO: push/pop handshake, entries visible at the head one cycle after push.
module hpdcache_fifo_reg #(
  parameter int unsigned DEPTH = 2,
  parameter type T = logic
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  T     wdata_i,
  output logic full_o,
  input  logic pop_i,
  output T     rdata_o,
  output logic empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_en, pop_en;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rptr_q];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_en) wptr_d = ptr_inc(wptr_q);
    if (pop_en)  rptr_d = ptr_inc(rptr_q);
    case ({push_en, pop_en})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage is not reset: contents are only observed while non-empty.
  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/hpdcache_mem_write_responder.sv
// Pairs independently arriving write meta and data beats, issues them to a
// backend write port and returns one in-order write response per write.
module hpdcache_mem_write_responder
  import hpdcache_pkg::*;
#(
  parameter int unsigned META_DEPTH = 2,
  parameter int unsigned DATA_DEPTH = 2,
  parameter int unsigned RESP_DEPTH = 2,
  parameter type hpdcache_mem_req_t    = hpdcache_pkg::hpdcache_mem_req_t,
  parameter type hpdcache_mem_req_w_t  = hpdcache_pkg::hpdcache_mem_req_w_t,
  parameter type hpdcache_mem_resp_w_t = hpdcache_pkg::hpdcache_mem_resp_w_t
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 mem_req_write_valid_i,
  output logic                 mem_req_write_ready_o,
  input  hpdcache_mem_req_t    mem_req_write_i,
  input  logic                 mem_req_write_data_valid_i,
  output logic                 mem_req_write_data_ready_o,
  input  hpdcache_mem_req_w_t  mem_req_write_data_i,
  output logic                 wr_valid_o,
  input  logic                 wr_ready_i,
  output logic [ADDR_W-1:0]    wr_addr_o,
  output logic [DATA_W-1:0]    wr_data_o,
  output logic [BE_W-1:0]      wr_be_o,
  output logic                 mem_resp_write_valid_o,
  input  logic                 mem_resp_write_ready_i,
  output hpdcache_mem_resp_w_t mem_resp_write_o
);

  hpdcache_mem_req_t    meta_head;
  hpdcache_mem_req_w_t  data_head;
  hpdcache_mem_resp_w_t resp_push;
  logic meta_full, meta_empty;
  logic data_full, data_empty;
  logic resp_full, resp_empty;
  logic wr_fire;

  assign mem_req_write_ready_o      = ~meta_full;
  assign mem_req_write_data_ready_o = ~data_full;

  // A write is offered only when a response slot is guaranteed for it.
  assign wr_valid_o = ~meta_empty & ~data_empty & ~resp_full;
  assign wr_fire    = wr_valid_o & wr_ready_i;
  assign wr_addr_o  = meta_head.mem_req_addr;
  assign wr_data_o  = data_head.mem_req_w_data;
  assign wr_be_o    = data_head.mem_req_w_be;

  assign mem_resp_write_valid_o = ~resp_empty;

  always_comb begin
    resp_push               = '0;
    resp_push.mem_resp_w_id = meta_head.mem_req_id;
  end

  hpdcache_fifo_reg #(.DEPTH(META_DEPTH), .T(hpdcache_mem_req_t)) u_meta_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (mem_req_write_valid_i),
    .wdata_i (mem_req_write_i),
    .full_o  (meta_full),
    .pop_i   (wr_fire),
    .rdata_o (meta_head),
    .empty_o (meta_empty)
  );

  hpdcache_fifo_reg #(.DEPTH(DATA_DEPTH), .T(hpdcache_mem_req_w_t)) u_data_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (mem_req_write_data_valid_i),
    .wdata_i (mem_req_write_data_i),
    .full_o  (data_full),
    .pop_i   (wr_fire),
    .rdata_o (data_head),
    .empty_o (data_empty)
  );

  hpdcache_fifo_reg #(.DEPTH(RESP_DEPTH), .T(hpdcache_mem_resp_w_t)) u_resp_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (wr_fire),
    .wdata_i (resp_push),
    .full_o  (resp_full),
    .pop_i   (mem_resp_write_ready_i),
    .rdata_o (mem_resp_write_o),
    .empty_o (resp_empty)
  );

endmodule

// File: tb/tb_hpdcache_mem_write_responder.sv
// Directed bench for hpdcache_mem_write_responder with a negedge write/response recorder.
module tb_hpdcache_mem_write_responder;
  import hpdcache_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic mem_req_write_valid_i, mem_req_write_ready_o;
  hpdcache_mem_req_t mem_req_write_i;
  logic mem_req_write_data_valid_i, mem_req_write_data_ready_o;
  hpdcache_mem_req_w_t mem_req_write_data_i;
  logic wr_valid_o, wr_ready_i;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [DATA_W-1:0] wr_data_o;
  logic [BE_W-1:0] wr_be_o;
  logic mem_resp_write_valid_o, mem_resp_write_ready_i;
  hpdcache_mem_resp_w_t mem_resp_write_o;

  int total = 0;
  int bad = 0;

  logic [ADDR_W-1:0] wa_q[$];
  logic [DATA_W-1:0] wd_q[$];
  logic [BE_W-1:0]   wb_q[$];
  logic [ID_W-1:0]   rid_q[$];

  logic stall_q = 1'b0;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_data;
  logic [BE_W-1:0]   hold_be;

  always #5 clk = ~clk;

  hpdcache_mem_write_responder dut (
    .clk_i                      (clk),
    .rst_i                      (rst),
    .mem_req_write_valid_i      (mem_req_write_valid_i),
    .mem_req_write_ready_o      (mem_req_write_ready_o),
    .mem_req_write_i            (mem_req_write_i),
    .mem_req_write_data_valid_i (mem_req_write_data_valid_i),
    .mem_req_write_data_ready_o (mem_req_write_data_ready_o),
    .mem_req_write_data_i       (mem_req_write_data_i),
    .wr_valid_o                 (wr_valid_o),
    .wr_ready_i                 (wr_ready_i),
    .wr_addr_o                  (wr_addr_o),
    .wr_data_o                  (wr_data_o),
    .wr_be_o                    (wr_be_o),
    .mem_resp_write_valid_o     (mem_resp_write_valid_o),
    .mem_resp_write_ready_i     (mem_resp_write_ready_i),
    .mem_resp_write_o           (mem_resp_write_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    wa_q.delete(); wd_q.delete(); wb_q.delete(); rid_q.delete();
  endtask

  // Record every fired write/response; check the write command holds while stalled.
  always @(negedge clk) begin
    if (!rst) begin
      if (stall_q) begin
        chk("hold_valid", 64'(wr_valid_o), 64'd1);
        chk("hold_addr", 64'(wr_addr_o), 64'(hold_addr));
        chk("hold_data", 64'(wr_data_o), 64'(hold_data));
        chk("hold_be", 64'(wr_be_o), 64'(hold_be));
      end
      if (wr_valid_o && wr_ready_i) begin
        wa_q.push_back(wr_addr_o); wd_q.push_back(wr_data_o); wb_q.push_back(wr_be_o);
      end
      if (mem_resp_write_valid_o && mem_resp_write_ready_i)
        rid_q.push_back(mem_resp_write_o.mem_resp_w_id);
      stall_q   = wr_valid_o && !wr_ready_i;
      hold_addr = wr_addr_o;
      hold_data = wr_data_o;
      hold_be   = wr_be_o;
    end else begin
      stall_q = 1'b0;
    end
  end

  task automatic send_meta(input logic [ADDR_W-1:0] a, input logic [ID_W-1:0] id);
    logic ok;
    logic done;
    done = 1'b0;
    mem_req_write_valid_i = 1'b1;
    mem_req_write_i.mem_req_addr = a;
    mem_req_write_i.mem_req_id   = id;
    for (int n = 0; n < 200 && !done; n++) begin
      ok = mem_req_write_ready_o;
      tick();
      if (ok) done = 1'b1;
    end
    mem_req_write_valid_i = 1'b0;
    if (!done) chk("meta_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_data(input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
    logic ok;
    logic done;
    done = 1'b0;
    mem_req_write_data_valid_i = 1'b1;
    mem_req_write_data_i.mem_req_w_data = d;
    mem_req_write_data_i.mem_req_w_be   = be;
    for (int n = 0; n < 200 && !done; n++) begin
      ok = mem_req_write_data_ready_o;
      tick();
      if (ok) done = 1'b1;
    end
    mem_req_write_data_valid_i = 1'b0;
    if (!done) chk("data_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_resp(input int n);
    for (int k = 0; k < 300 && rid_q.size() < n; k++) tick();
    chk("resp_count", 64'(rid_q.size()), 64'(n));
  endtask

  logic [ADDR_W-1:0] ra [10];
  logic [DATA_W-1:0] rd [10];
  logic [BE_W-1:0]   rb [10];
  logic tog_done;

  initial begin
    rst = 1'b1;
    mem_req_write_valid_i = 1'b0;
    mem_req_write_i = '0;
    mem_req_write_data_valid_i = 1'b0;
    mem_req_write_data_i = '0;
    wr_ready_i = 1'b1;
    mem_resp_write_ready_i = 1'b1;
    #2;
    chk("rst_meta_ready", 64'(mem_req_write_ready_o), 64'd1);
    chk("rst_data_ready", 64'(mem_req_write_data_ready_o), 64'd1);
    chk("rst_wr_valid", 64'(wr_valid_o), 64'd0);
    chk("rst_resp_valid", 64'(mem_resp_write_valid_o), 64'd0);
    tick();
    rst = 1'b0;

    // Same-cycle meta and data: write at t+1, response at t+2.
    clr();
    mem_req_write_valid_i = 1'b1;
    mem_req_write_i.mem_req_addr = 32'h100;
    mem_req_write_i.mem_req_id   = 4'd3;
    mem_req_write_data_valid_i = 1'b1;
    mem_req_write_data_i.mem_req_w_data = 16'hA5A5;
    mem_req_write_data_i.mem_req_w_be   = 2'h3;
    tick();
    mem_req_write_valid_i = 1'b0;
    mem_req_write_data_valid_i = 1'b0;
    chk("t1_wr_valid", 64'(wr_valid_o), 64'd1);
    chk("t1_addr", 64'(wr_addr_o), 64'h100);
    chk("t1_data", 64'(wr_data_o), 64'hA5A5);
    chk("t1_be", 64'(wr_be_o), 64'h3);
    chk("t1_resp_early", 64'(mem_resp_write_valid_o), 64'd0);
    tick();
    chk("t1_resp_valid", 64'(mem_resp_write_valid_o), 64'd1);
    chk("t1_resp_id", 64'(mem_resp_write_o.mem_resp_w_id), 64'd3);
    chk("t1_wr_done", 64'(wr_valid_o), 64'd0);
    tick();
    chk("t1_resp_drained", 64'(mem_resp_write_valid_o), 64'd0);
    chk("t1_nwrites", 64'(wa_q.size()), 64'd1);

    // Data first, meta five cycles later.
    clr();
    send_data(16'h1234, 2'h1);
    for (int i = 0; i < 5; i++) begin
      chk("t2_no_write", 64'(wr_valid_o), 64'd0);
      tick();
    end
    send_meta(32'h200, 4'd5);
    chk("t2_wr_valid", 64'(wr_valid_o), 64'd1);
    chk("t2_addr", 64'(wr_addr_o), 64'h200);
    chk("t2_data", 64'(wr_data_o), 64'h1234);
    chk("t2_be", 64'(wr_be_o), 64'h1);
    wait_resp(1);
    chk("t2_id", 64'(rid_q[0]), 64'd5);

    // Meta FIFO fills with no data, then data drains in order.
    clr();
    fork
      begin
        send_meta(32'h10, 4'd1);
        send_meta(32'h20, 4'd2);
        send_meta(32'h30, 4'd3);
      end
      begin
        tick(); tick();
        chk("t3_meta_full", 64'(mem_req_write_ready_o), 64'd0);
        tick(); tick(); tick();
        chk("t3_no_write", 64'(wr_valid_o), 64'd0);
        send_data(16'h0001, 2'h3);
        send_data(16'h0002, 2'h2);
        send_data(16'h0003, 2'h1);
      end
    join
    wait_resp(3);
    for (int i = 0; i < 3; i++) begin
      chk("t3_id", 64'(rid_q[i]), 64'(i + 1));
      chk("t3_addr", 64'(wa_q[i]), 64'((i + 1) * 16));
      chk("t3_data", 64'(wd_q[i]), 64'(i + 1));
    end

    // Response FIFO full blocks further writes.
    clr();
    mem_resp_write_ready_i = 1'b0;
    fork
      for (int i = 0; i < 4; i++) send_meta(32'(32'h400 + i), 4'(i + 4));
      for (int i = 0; i < 4; i++) send_data(16'(16'hB000 + i), 2'h3);
    join
    repeat (5) tick();
    chk("t4_nwrites", 64'(wa_q.size()), 64'd2);
    chk("t4_wr_blocked", 64'(wr_valid_o), 64'd0);
    chk("t4_resp_valid", 64'(mem_resp_write_valid_o), 64'd1);
    mem_resp_write_ready_i = 1'b1;
    wait_resp(4);
    for (int i = 0; i < 4; i++) begin
      chk("t4_id", 64'(rid_q[i]), 64'(i + 4));
      chk("t4_addr", 64'(wa_q[i]), 64'(32'h400 + i));
    end

    // Backend ready toggling over ten random pairs.
    clr();
    for (int i = 0; i < 10; i++) begin
      ra[i] = $urandom;
      rd[i] = 16'($urandom);
      rb[i] = 2'($urandom);
    end
    tog_done = 1'b0;
    wr_ready_i = 1'b0;
    fork
      begin
        fork
          for (int i = 0; i < 10; i++) send_meta(ra[i], 4'(i));
          for (int i = 0; i < 10; i++) send_data(rd[i], rb[i]);
        join
        tog_done = 1'b1;
      end
      while (!tog_done) begin
        tick();
        wr_ready_i = ~wr_ready_i;
      end
    join
    wr_ready_i = 1'b1;
    wait_resp(10);
    for (int i = 0; i < 10; i++) begin
      chk("t5_id", 64'(rid_q[i]), 64'(i));
      chk("t5_addr", 64'(wa_q[i]), 64'(ra[i]));
      chk("t5_data", 64'(wd_q[i]), 64'(rd[i]));
      chk("t5_be", 64'(wb_q[i]), 64'(rb[i]));
    end

    // Reset with buffered metas and a pending response.
    clr();
    mem_resp_write_ready_i = 1'b0;
    fork
      send_meta(32'h700, 4'd7);
      send_data(16'h0707, 2'h3);
    join
    tick(); tick();
    send_meta(32'hAA, 4'd1);
    send_meta(32'hBB, 4'd2);
    chk("t6_resp_pending", 64'(mem_resp_write_valid_o), 64'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_wr_valid", 64'(wr_valid_o), 64'd0);
    chk("t6_rst_resp_valid", 64'(mem_resp_write_valid_o), 64'd0);
    chk("t6_rst_meta_ready", 64'(mem_req_write_ready_o), 64'd1);
    tick();
    rst = 1'b0;
    clr();
    mem_resp_write_ready_i = 1'b1;
    send_data(16'h7777, 2'h2);
    repeat (5) tick();
    chk("t6_no_stale_write", 64'(wa_q.size()), 64'd0);
    chk("t6_no_stale_resp", 64'(rid_q.size()), 64'd0);
    send_meta(32'h300, 4'd9);
    wait_resp(1);
    chk("t6_addr", 64'(wa_q[0]), 64'h300);
    chk("t6_data", 64'(wd_q[0]), 64'h7777);
    chk("t6_id", 64'(rid_q[0]), 64'd9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
